// File: rtl/mux_scanner_if.sv
// Control and status bundle for mux_scanner. The tri-state serial line Y is not part of this
// bundle; it stays a plain port so it can be wired straight to a pad or bus net.
interface mux_scanner_if;
   logic       EN;     // active-low enable
   logic [7:0] D;
   logic       start;
   logic [2:0] A;
   logic       busy;
   logic       done;

   modport master (
      output EN, D, start,
      input  A, busy, done
   );

   modport slave (
      input  EN, D, start,
      output A, busy, done
   );
endinterface

// File: rtl/mux_scanner.sv
// Parallel-to-serial channel scanner: captures D, drives D[0..7] on a tri-state Y with the
// channel index on A. Define MUX_SCAN_PARITY_EN to append one even-parity bit per frame.
module mux_scanner (
   input  logic         clk,
   input  logic         rst_n,
   mux_scanner_if.slave bus,
   output wire          Y
);

`ifdef MUX_SCAN_PARITY_EN
   typedef enum logic [1:0] {StIdle, StScan, StPar, StDone} state_e;
`else
   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;
`endif

   state_e     state_q, state_d;
   logic [2:0] a_q, a_d;
   logic [7:0] shadow_q, shadow_d;
   logic       y_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= 3'd0;
         shadow_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         shadow_q <= shadow_d;
      end
   end

   // EN high pauses SCAN/PAR by holding everything; DONE always retires to IDLE.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      shadow_d = shadow_q;
      case (state_q)
         StIdle: begin
            if (!bus.EN && bus.start) begin
               shadow_d = bus.D;
               a_d      = 3'd0;
               state_d  = StScan;
            end
         end
         StScan: begin
            if (!bus.EN) begin
               a_d = a_q + 3'd1;
               if (a_q == 3'd7) begin
`ifdef MUX_SCAN_PARITY_EN
                  state_d = StPar;
`else
                  state_d = StDone;
`endif
               end
            end
         end
`ifdef MUX_SCAN_PARITY_EN
         StPar: begin
            if (!bus.EN) begin
               a_d     = 3'd0;
               state_d = StDone;
            end
         end
`endif
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      y_bit = 1'b0;
      case (state_q)
         StScan:  y_bit = shadow_q[a_q];
`ifdef MUX_SCAN_PARITY_EN
         StPar:   y_bit = ^shadow_q;
`endif
         default: y_bit = 1'b0;
      endcase
   end

   assign Y = bus.EN ? 1'bz : y_bit;

   assign bus.A    = a_q;
`ifdef MUX_SCAN_PARITY_EN
   assign bus.busy = (state_q == StScan) || (state_q == StPar);
`else
   assign bus.busy = (state_q == StScan);
`endif
   assign bus.done = (state_q == StDone);

endmodule

// File: tb/tb_mux_scanner.sv
// Directed bench for mux_scanner: each accepted start pushes the expected per-cycle frame
// into a scoreboard queue, which is popped and checked as the scan runs.
module tb_mux_scanner;

`ifdef MUX_SCAN_PARITY_EN
   localparam int Frame = 9;
`else
   localparam int Frame = 8;
`endif

   typedef struct packed {
      logic       y;
      logic [2:0] a;
      logic       busy;
      logic       done;
   } exp_t;

   logic clk;
   logic rst_n;
   wire  y;
   int   n_assert;
   int   n_fail;
   int   cyc_n;
   exp_t sb[$];

   mux_scanner_if ifc ();

   // Released Y floats high so a tri-stated line reads as 1.
   pullup (y);

   mux_scanner dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc),
      .Y     (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc_n, got, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] d);
      for (int i = 0; i < 8; i++) sb.push_back('{d[i], 3'(i), 1'b1, 1'b0});
`ifdef MUX_SCAN_PARITY_EN
      sb.push_back('{^d, 3'd0, 1'b1, 1'b0});
`endif
      sb.push_back('{1'b0, 3'd0, 1'b0, 1'b1});
   endtask

   // One clock cycle: drive inputs just after the edge, check outputs at the falling edge.
   task automatic cyc(input logic en, input logic st, input logic [7:0] d);
      exp_t e;
      logic idle;
      @(posedge clk);
      #1;
      ifc.EN    = en;
      ifc.start = st;
      ifc.D     = d;
      @(negedge clk);
      cyc_n++;
      idle = (sb.size() == 0);
      if (idle) begin
         e = '{en, 3'd0, 1'b0, 1'b0};
      end else if (sb[0].busy && en) begin
         e = '{1'b1, sb[0].a, 1'b1, 1'b0};
      end else begin
         e = sb.pop_front();
         if (en) e.y = 1'b1;
      end
      chk("y", {7'd0, y}, {7'd0, e.y});
      chk("a", {5'd0, ifc.A}, {5'd0, e.a});
      chk("busy", {7'd0, ifc.busy}, {7'd0, e.busy});
      chk("done", {7'd0, ifc.done}, {7'd0, e.done});
      if (idle && !en && st && rst_n) push_frame(d);
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      cyc_n     = 0;
      rst_n     = 1'b0;
      ifc.EN    = 1'b0;
      ifc.start = 1'b0;
      ifc.D     = 8'h00;

      // Reset values, Y driven low when enabled and floating when disabled.
      #3;
      chk("rst_y", {7'd0, y}, 8'd0);
      chk("rst_a", {5'd0, ifc.A}, 8'd0);
      chk("rst_busy", {7'd0, ifc.busy}, 8'd0);
      chk("rst_done", {7'd0, ifc.done}, 8'd0);
      ifc.EN = 1'b1;
      #1;
      chk("rst_y_z", {7'd0, y}, 8'd1);
      ifc.EN = 1'b0;
      #10 rst_n = 1'b1;

      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);

      // Basic scan of A5.
      cyc(1'b0, 1'b1, 8'hA5);
      for (int i = 0; i <= Frame; i++) cyc(1'b0, 1'b0, 8'hA5);
      cyc(1'b0, 1'b0, 8'h00);

      // start ignored while disabled in IDLE, and mid-scan; D changes mid-scan.
      cyc(1'b1, 1'b1, 8'hFF);
      cyc(1'b1, 1'b1, 8'hFF);
      cyc(1'b0, 1'b1, 8'h96);
      for (int i = 0; i <= Frame; i++) cyc(1'b0, (i == 3), 8'hFF);

      // Pause for 3 cycles at A=4 (D[4]=0, so a driven line would read 0).
      cyc(1'b0, 1'b1, 8'hE7);
      for (int i = 0; i <= Frame + 3; i++) cyc((i >= 4 && i < 7), 1'b0, 8'h00);

      // Parity frames; the second also disables during DONE.
      cyc(1'b0, 1'b1, 8'h07);
      for (int i = 0; i <= Frame; i++) cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 8'h03);
      for (int i = 0; i <= Frame; i++) cyc((i == Frame), 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);

      // Asynchronous reset at A=5 aborts the scan.
      cyc(1'b0, 1'b1, 8'hC3);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'hC3);
      rst_n = 1'b0;
      #1;
      chk("arst_a", {5'd0, ifc.A}, 8'd0);
      chk("arst_busy", {7'd0, ifc.busy}, 8'd0);
      chk("arst_done", {7'd0, ifc.done}, 8'd0);
      chk("arst_y", {7'd0, y}, 8'd0);
      sb.delete();
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;
      cyc(1'b0, 1'b1, 8'h01);
      for (int i = 0; i <= Frame; i++) cyc(1'b0, 1'b0, 8'h00);

      // start held high: frames separated by DONE plus one IDLE cycle.
      for (int i = 0; i <= 2 * (Frame + 2); i++) cyc(1'b0, 1'b1, 8'h3C);
      for (int i = 0; i <= Frame; i++) cyc(1'b0, 1'b0, 8'h00);
      chk("sb_drained", 8'(sb.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
